// File: rtl/alarm_pkg.sv
// Shared types and default timing for the alarm chime sequencer.
// The ESCALATED encoding is only reached when ALARM_CHIME_ESCALATE_EN is defined.
package alarm_pkg;

    localparam int BEEP_W              = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_ON_CYCLES       = 8;
    localparam int DEF_OFF_CYCLES      = 8;
    localparam int DEF_MAX_BEEPS       = 5;
    localparam int DEF_CNT_W           = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHIME_ON  = 3'd1,
        CHIME_OFF = 3'd2,
        MUTED     = 3'd3,
        ESCALATED = 3'd4
    } alarm_state_e;

    function automatic logic [BEEP_W-1:0] sat_inc(input logic [BEEP_W-1:0] v,
                                                  input logic [BEEP_W-1:0] lim);
        return (v >= lim) ? lim : v + 1'b1;
    endfunction

endpackage

// File: rtl/alarm_sync2.sv
// Two-flop synchroniser for a slow asynchronous level (alarm, door, ignition).
module alarm_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic [1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[0], i_async};
        end
    end

    assign o_sync = r_sync[1];

endmodule

// File: rtl/alarm_chime_sequencer.sv
// Debounces the synchronised alarm level and drives a timed beep pattern on the buzzer.
// Optional macro ALARM_CHIME_ESCALATE_EN: unacknowledged expiry holds the buzzer on (ESCALATED).
module alarm_chime_sequencer
    import alarm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int ON_CYCLES       = DEF_ON_CYCLES,
    parameter int OFF_CYCLES      = DEF_OFF_CYCLES,
    parameter int MAX_BEEPS       = DEF_MAX_BEEPS,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CarAlarmSignal,
    input  logic              AckButton,
    output logic              BuzzerOn,
    output logic              ChimeActive,
    output logic              Muted,
    output logic [BEEP_W-1:0] BeepCount
);

    localparam logic [CNT_W-1:0]  DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]  OFF_LAST = CNT_W'(OFF_CYCLES - 1);
    localparam logic [BEEP_W-1:0] MAX_B    = BEEP_W'(MAX_BEEPS);
`ifdef ALARM_CHIME_ESCALATE_EN
    localparam alarm_state_e EXPIRY_STATE = ESCALATED;
`else
    localparam alarm_state_e EXPIRY_STATE = MUTED;
`endif

    logic              w_alarm_s;
    alarm_state_e      r_state, w_state_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next;
    logic [BEEP_W-1:0] r_beep, w_beep_next;
    logic              r_buzzer, r_active, r_muted;
    logic              w_buzzer_next, w_active_next, w_muted_next;

    alarm_sync2 u_sync (
        .clk     (clk),
        .rst     (reset),
        .i_async (CarAlarmSignal),
        .o_sync  (w_alarm_s)
    );

    // Priority inside each chiming state: alarm drop, then ack, then phase expiry.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_beep_next  = r_beep;
        case (r_state)
            IDLE: begin
                if (!w_alarm_s) begin
                    w_cnt_next = '0;
                end else if (r_cnt == DEB_LAST) begin
                    w_state_next = CHIME_ON;
                    w_cnt_next   = '0;
                    w_beep_next  = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            CHIME_ON: begin
                if (!w_alarm_s) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else if (AckButton) begin
                    w_state_next = MUTED;
                    w_cnt_next   = '0;
                end else if (r_cnt == ON_LAST) begin
                    w_state_next = CHIME_OFF;
                    w_cnt_next   = '0;
                    w_beep_next  = sat_inc(r_beep, MAX_B);
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            CHIME_OFF: begin
                if (!w_alarm_s) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else if (AckButton) begin
                    w_state_next = MUTED;
                    w_cnt_next   = '0;
                end else if (r_cnt == OFF_LAST) begin
                    w_state_next = (r_beep == MAX_B) ? EXPIRY_STATE : CHIME_ON;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            MUTED: begin
                if (!w_alarm_s) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end
            end
`ifdef ALARM_CHIME_ESCALATE_EN
            ESCALATED: begin
                if (!w_alarm_s) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else if (AckButton) begin
                    w_state_next = MUTED;
                end
            end
`endif
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        w_buzzer_next = (w_state_next == CHIME_ON);
        w_active_next = (w_state_next == CHIME_ON) || (w_state_next == CHIME_OFF);
        w_muted_next  = (w_state_next == MUTED);
`ifdef ALARM_CHIME_ESCALATE_EN
        if (w_state_next == ESCALATED) begin
            w_buzzer_next = 1'b1;
            w_active_next = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_beep   <= '0;
            r_buzzer <= 1'b0;
            r_active <= 1'b0;
            r_muted  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_beep   <= w_beep_next;
            r_buzzer <= w_buzzer_next;
            r_active <= w_active_next;
            r_muted  <= w_muted_next;
        end
    end

    assign BuzzerOn    = r_buzzer;
    assign ChimeActive = r_active;
    assign Muted       = r_muted;
    assign BeepCount   = r_beep;

endmodule

// File: tb/tb_alarm_chime_sequencer.sv
// Table-driven bench for alarm_chime_sequencer with a scoreboard queue checked on the falling edge.
module tb_alarm_chime_sequencer;

    logic       clk;
    logic       reset;
    logic       CarAlarmSignal;
    logic       AckButton;
    logic       BuzzerOn;
    logic       ChimeActive;
    logic       Muted;
    logic [3:0] BeepCount;

`ifdef ALARM_CHIME_ESCALATE_EN
    localparam bit ESC = 1'b1;
`else
    localparam bit ESC = 1'b0;
`endif

    typedef struct {
        int         id;
        string      name;
        logic       alarm;
        logic       ack;
        int         n;
        logic       buz;
        logic       act;
        logic       mut;
        logic [3:0] beep;
    } vec_t;

    vec_t tbl[$];
    vec_t sb_q[$];
    int   n_vec = 0;
    int   n_mis = 0;

    alarm_chime_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .CarAlarmSignal (CarAlarmSignal),
        .AckButton      (AckButton),
        .BuzzerOn       (BuzzerOn),
        .ChimeActive    (ChimeActive),
        .Muted          (Muted),
        .BeepCount      (BeepCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input string nm, input logic al, input logic ak, input int n,
                                input logic bz, input logic ac, input logic mu, input int bp);
        vec_t v;
        v.id    = tbl.size();
        v.name  = nm;
        v.alarm = al;
        v.ack   = ak;
        v.n     = n;
        v.buz   = bz;
        v.act   = ac;
        v.mut   = mu;
        v.beep  = 4'(bp);
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic bz, input logic ac, input logic mu,
                           input logic [3:0] bp);
        chk({nm, ".BuzzerOn"},    {3'b0, BuzzerOn},    {3'b0, bz});
        chk({nm, ".ChimeActive"}, {3'b0, ChimeActive}, {3'b0, ac});
        chk({nm, ".Muted"},       {3'b0, Muted},       {3'b0, mu});
        chk({nm, ".BeepCount"},   BeepCount,           bp);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            vec_t e;
            e = sb_q.pop_front();
            chk_all(e.name, e.buz, e.act, e.mut, e.beep);
            $display("vec %0d %s: alarm=%0b ack=%0b buzz=%0b active=%0b muted=%0b beep=%0d",
                     e.id, e.name, e.alarm, e.ack, BuzzerOn, ChimeActive, Muted, BeepCount);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Glitch shorter than the debounce window, then exactly the debounce window.
        add("idle",        0, 0, 2, 0, 0, 0, 0);
        add("glitch3",     1, 0, 3, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add("glitch_tail", 0, 0, 1, 0, 0, 0, 0);
        add("deb4_hold",   1, 0, 4, 0, 0, 0, 0);
        add("deb4_wait",   0, 0, 1, 0, 0, 0, 0);
        add("deb4_fire",   0, 0, 1, 1, 1, 0, 0);
        add("deb4_drop",   0, 0, 1, 0, 0, 0, 0);
        add("settle",      0, 0, 2, 0, 0, 0, 0);
        // Steady alarm: five full beeps, then expiry.
        add("steady_deb",  1, 0, 5, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            add("on_start",  1, 0, 1, 1, 1, 0, k - 1);
            add("on_end",    1, 0, 7, 1, 1, 0, k - 1);
            add("off_start", 1, 0, 1, 0, 1, 0, k);
            add("off_end",   1, 0, 7, 0, 1, 0, k);
        end
        add("expiry",      1, 0, 1,  ESC, ESC, !ESC, 5);
        add("expiry_hold", 1, 0, 20, ESC, ESC, !ESC, 5);
        add("ack_after",   1, 1, 1,  0, 0, 1, 5);
        add("muted_hold",  1, 0, 2,  0, 0, 1, 5);
        add("drop_sync",   0, 0, 2,  0, 0, 1, 5);
        add("drop_idle",   0, 0, 1,  0, 0, 0, 5);
        add("idle_hold",   0, 0, 2,  0, 0, 0, 5);
        // Ack during beep 2 ON, then drop and re-arm.
        add("restart",     1, 0, 6, 1, 1, 0, 0);
        add("b1_on",       1, 0, 7, 1, 1, 0, 0);
        add("b1_off",      1, 0, 1, 0, 1, 0, 1);
        add("b1_off_end",  1, 0, 7, 0, 1, 0, 1);
        add("b2_on",       1, 0, 1, 1, 1, 0, 1);
        add("b2_on_c3",    1, 0, 2, 1, 1, 0, 1);
        add("ack_mute",    1, 1, 1, 0, 0, 1, 1);
        add("ack_hold",    1, 0, 3, 0, 0, 1, 1);
        add("ack_drop",    0, 0, 2, 0, 0, 1, 1);
        add("ack_idle",    0, 0, 1, 0, 0, 0, 1);
        add("ack_idle2",   0, 0, 2, 0, 0, 0, 1);
        add("rearm",       1, 0, 6, 1, 1, 0, 0);
        // Ack in the same cycle the synchronised alarm falls: drop wins.
        add("sim_pre",     0, 0, 2, 1, 1, 0, 0);
        add("sim_ack_drop",0, 1, 1, 0, 0, 0, 0);
        add("sim_after",   0, 0, 3, 0, 0, 0, 0);

        reset          = 1'b1;
        CarAlarmSignal = 1'b0;
        AckButton      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset_state", 0, 0, 0, 4'd0);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            CarAlarmSignal = tbl[i].alarm;
            AckButton      = tbl[i].ack;
            repeat (tbl[i].n) @(posedge clk);
            #1;
            sb_q.push_back(tbl[i]);
        end
        AckButton = 1'b0;
        @(negedge clk);
        #1;

        // Asynchronous reset on cycle 3 of beep 2 ON.
        CarAlarmSignal = 1'b1;
        repeat (24) @(posedge clk);
        #2;
        chk_all("pre_reset", 1, 1, 0, 4'd1);
        reset          = 1'b1;
        CarAlarmSignal = 1'b0;
        #1;
        chk_all("async_reset", 0, 0, 0, 4'd0);
        @(posedge clk);
        #1;
        chk_all("reset_held", 0, 0, 0, 4'd0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all("post_reset", 0, 0, 0, 4'd0);

        if (sb_q.size() != 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/alarm_chime_sequencer.md
Name: alarm_chime_sequencer

Overview:
Downstream consumer of the combinational car-alarm output (CarAlarmSignal). Synchronises and debounces the alarm level, then drives a buzzer with a timed on/off beep pattern. The pattern runs for a bounded number of beeps or until the driver acknowledges. It sits between the alarm condition logic and the physical buzzer driver, and is exercised by the same tester/monitor bench style.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronised-high cycles required before chiming starts (>=1)
ON_CYCLES, 8, buzzer-on cycles per beep (>=1)
OFF_CYCLES, 8, buzzer-off cycles between beeps (>=1)
MAX_BEEPS, 5, beeps before automatic mute (1..15)
CNT_W, 8, width of the shared phase/debounce counter; must hold max(DEBOUNCE_CYCLES, ON_CYCLES, OFF_CYCLES)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
CarAlarmSignal  input  1  raw alarm level from alarm logic; asynchronous to clk
AckButton  input  1  driver acknowledge, synchronous level, sampled every cycle
BuzzerOn  output  1  registered buzzer drive
ChimeActive  output  1  high in CHIME_ON or CHIME_OFF
Muted  output  1  high in MUTED
BeepCount  output  4  completed beeps in the current episode, saturating at MAX_BEEPS

Behaviour:
- One clock; reset is asynchronous and active-high. While reset is high, all outputs are 0, the state is IDLE, and counters and synchronisers are 0.
- Reset asserted mid-pattern forces the reset state immediately, with no completion of the current beep.
- CarAlarmSignal passes through a 2-FF synchroniser giving alarm_s. Input-to-alarm_s latency is 2 cycles.
- All outputs are registered and decoded from the next state.
- IDLE:
  - Counter increments while alarm_s=1; any alarm_s=0 clears it.
  - When the counter reaches DEBOUNCE_CYCLES, go to CHIME_ON, clear the counter and clear BeepCount.
  - AckButton is ignored in IDLE.
- CHIME_ON:
  - BuzzerOn=1 for exactly ON_CYCLES cycles.
  - On the last cycle, BeepCount increments (saturating) and the state goes to CHIME_OFF.
- CHIME_OFF:
  - BuzzerOn=0 for OFF_CYCLES cycles.
  - At the end, go to MUTED if BeepCount==MAX_BEEPS, otherwise back to CHIME_ON.
- AckButton=1 in CHIME_ON or CHIME_OFF: go to MUTED next cycle; BuzzerOn drops the same edge.
- MUTED: BuzzerOn=0 and BeepCount held. Leave to IDLE only when alarm_s=0, so the chime re-arms only after the condition clears.
- alarm_s=0 in any non-IDLE state: go to IDLE next cycle, with BuzzerOn=0 and counter cleared. BeepCount is held until the next episode starts.
- Priority on simultaneous events: reset > alarm_s drop > AckButton > phase-counter expiry.
- Counter wrap is impossible by the CNT_W rule; no other arithmetic overflow paths exist.

Optional Feature:
Macro: ALARM_CHIME_ESCALATE_EN.
- Defined: reaching MAX_BEEPS without an ack enters state ESCALATED instead of MUTED.
  - BuzzerOn is held continuously at 1; ChimeActive=1, Muted=0.
  - AckButton goes to MUTED; alarm_s=0 goes to IDLE.
- Undefined: no ESCALATED state or logic exists, and expiry goes to MUTED as described above.

Decomposition:
- Package alarm_pkg holds:
  - the state encoding enum/localparams (IDLE, CHIME_ON, CHIME_OFF, MUTED, ESCALATED);
  - the BEEP_W=4 constant;
  - default timing constants.
- One sub-module, alarm_sync2: the 2-FF synchroniser, reusable for future door/ignition inputs.
- The FSM and counters stay in the top module.

Test Plan:
- Reset mid-CHIME_ON (cycle 3 of ON) -> all outputs 0 asynchronously, state IDLE, BeepCount=0 after release.
- Glitch: CarAlarmSignal high 3 cycles then low -> with DEBOUNCE_CYCLES=4, BuzzerOn never asserts and ChimeActive stays 0.
- Steady alarm, defaults -> BuzzerOn first rises 2+4 cycles after input; 8 on / 8 off, 5 beeps; BeepCount steps 1..5; then Muted=1 and BuzzerOn=0 while alarm stays high.
- AckButton pulse during beep 2 ON phase -> BuzzerOn=0 next cycle, Muted=1, BeepCount=1; drop alarm -> IDLE 3 cycles later (2 sync + 1), re-raise restarts with BeepCount=0.
- AckButton and alarm drop in the same cycle -> state IDLE, not MUTED; Muted stays 0.
- With ALARM_CHIME_ESCALATE_EN, steady alarm -> after beep 5 OFF phase, BuzzerOn=1 continuously; AckButton -> Muted=1 and BuzzerOn=0.
